sram_axi_bridge: RTL and testbench
==================================

Name: sram_axi_bridge

Overview:
- Arbiter and protocol converter that shares one AXI3 master port between the two sram-like ports of the CPU: instruction fetch and data load/store.
- Instruction fetch drives a read-only port. Data load/store drives a read/write port.
- Sits between the pipeline's inst/data sram-like interfaces and the SoC AXI interconnect.
- Arbitrates the single AR channel (data reads win), owns the AW/W/B sequencing for stores, and returns read data to the right requester by RID.
- Keeps each sram-like port strictly in order.

Parameters:
INST_ID, 4'd0, ARID used for instruction reads
DATA_ID, 4'd1, ARID/AWID used for data reads and writes

Ports:
clk  input  1  clock
resetn  input  1  synchronous active-low reset
inst_sram_req  input  1  instruction read request
inst_sram_size  input  2  00 byte, 01 half, 10 word
inst_sram_addr  input  32  instruction address
inst_sram_addr_ok  output  1  request accepted this cycle
inst_sram_data_ok  output  1  read data valid this cycle
inst_sram_rdata  output  32  read data
data_sram_req  input  1  data request
data_sram_wr  input  1  1 write, 0 read
data_sram_size  input  2  access size
data_sram_wstrb  input  4  byte enables
data_sram_addr  input  32  data address
data_sram_wdata  input  32  write data
data_sram_addr_ok  output  1  request accepted this cycle
data_sram_data_ok  output  1  read data valid or write complete
data_sram_rdata  output  32  read data
arid  output  4  read ID
araddr  output  32  read address
arsize  output  3  {1'b0, size}
arvalid  output  1  AR valid
arready  input  1  AR ready
rid  input  4  read ID
rdata  input  32  read data
rvalid  input  1  R valid
rready  output  1  R ready
awaddr  output  32  write address
awsize  output  3  {1'b0, size}
awvalid  output  1  AW valid
awready  input  1  AW ready
wdata  output  32  write data
wstrb  output  4  write strobes
wvalid  output  1  W valid
wready  input  1  W ready
bvalid  input  1  B response valid
bready  output  1  B ready

The remaining fixed AXI fields are tied off in the top-level wrapper, not in this block: arlen/awlen=0, burst=01, lock/cache/prot=0, wid=1, wlast=1.

Behaviour:
- Reset is synchronous and active-low on clk. While resetn=0:
  - all FSMs go to IDLE and all outstanding flags clear;
  - arvalid, awvalid, wvalid, bready, addr_ok and data_ok outputs are 0;
  - registered address/data fields are 0.
  - Any transaction in flight when reset is asserted is abandoned; no data_ok is issued for it afterwards.
- Outstanding limits: each sram-like port may have at most one transaction outstanding.
  - inst_pend is set on inst addr_ok and cleared on its data_ok.
  - data_pend is set on data addr_ok (read or write) and cleared on its data_ok.
  - A port's addr_ok is never asserted while its own pend flag is set.
- AR FSM, states AR_IDLE and AR_SEND.
  - In AR_IDLE, candidates are:
    - data: data_sram_req & !data_sram_wr & !data_pend;
    - inst: inst_sram_req & !inst_pend & !raw_hit.
  - When both are candidates, data wins.
  - The winner's addr_ok is driven combinationally in the same cycle. arid/araddr/arsize are registered and the FSM moves to AR_SEND.
  - In AR_SEND, arvalid=1 and is held stable until arready; then the FSM returns to AR_IDLE.
  - Nothing is accepted while in AR_SEND.
  - Minimum addr_ok-to-arvalid latency is 1 cycle.
- R channel:
  - rready is held at 1 whenever resetn=1.
  - rvalid & rid==INST_ID: inst_sram_data_ok=1 in the same cycle, inst_sram_rdata=rdata.
  - rvalid & rid==DATA_ID: data_sram_data_ok=1 in the same cycle, data_sram_rdata=rdata.
  - rresp is ignored.
- Write FSM, states W_IDLE, W_SEND, W_RESP.
  - In W_IDLE with data_sram_req & data_sram_wr & !data_pend: data_sram_addr_ok=1; awaddr/awsize/wdata/wstrb are registered and the FSM moves to W_SEND.
  - In W_SEND, awvalid and wvalid both start at 1. Each drops independently after its own handshake (aw_done/w_done flags).
  - When both handshakes have completed (possibly in the same cycle), the FSM moves to W_RESP.
  - In W_RESP, bready=1; on bvalid, data_sram_data_ok=1 for one cycle and the FSM returns to W_IDLE.
- data_sram_addr_ok is a single signal: the OR of read acceptance and write acceptance, which are mutually exclusive.
- RAW hazard, inst after store:
  - raw_hit = inst_sram_addr[31:2] equals awaddr[31:2] while the write FSM is not in W_IDLE, or equals data_sram_addr[31:2] while a data write is being accepted this cycle.
  - While raw_hit is high, the inst read is stalled with no addr_ok.
- Simultaneous events:
  - inst and data read accepted in the same cycle: impossible, since there is one AR slot.
  - inst read accepted in the same cycle as a data write: allowed if no raw_hit.
  - R beats for both IDs cannot coincide (single R channel).
  - A data R and a B cannot both target the data port (data_pend).

Test Plan:
- Reset, then inst_sram_req=1 addr=0x1c000000 with arready=1:
  - addr_ok in cycle 0; arvalid/araddr=0x1c000000/arid=0 in cycle 1.
  - rvalid rid=0 rdata=0x02800000 gives inst_sram_data_ok=1 with that rdata.
- inst read 0x1c000004 and data read 0x00001000 requested in the same cycle:
  - data gets addr_ok first with arid=1; inst addr_ok comes only after the AR handshake.
  - An R with rid=1 must not pulse inst_sram_data_ok.
- Data write addr=0x00000100 wdata=0xdeadbeef wstrb=4'b0011:
  - awready asserted 2 cycles before wready; awvalid drops on its own handshake while wvalid is held.
  - W_RESP is entered only after both handshakes.
  - bvalid gives data_sram_data_ok for 1 cycle; a second data request gets no addr_ok before that.
- Store pending to 0x1c000010, inst read 0x1c000010:
  - no inst addr_ok until the B completes; inst read to 0x1c000014 is accepted meanwhile.
- arready held 0 for 5 cycles:
  - arvalid stays 1 and araddr stays stable throughout.
  - No further addr_ok on either port.
- resetn=0 while in W_SEND and AR_SEND:
  - next cycle all valids are 0 and states are IDLE.
  - A late rvalid/bvalid after reset produces no data_ok.

Source files
------------

// File: rtl/sram_axi_bridge.sv
// Shares one AXI3 master between the instruction-fetch (read-only) and data
// (read/write) sram-like ports; each port keeps at most one transaction in flight.
module sram_axi_bridge #(
    parameter logic [3:0] INST_ID = 4'd0,
    parameter logic [3:0] DATA_ID = 4'd1
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_sram_req,
    input  logic [1:0]  inst_sram_size,
    input  logic [31:0] inst_sram_addr,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,

    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [2:0]  arsize,
    output logic        arvalid,
    input  logic        arready,

    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic        rvalid,
    output logic        rready,

    output logic [31:0] awaddr,
    output logic [2:0]  awsize,
    output logic        awvalid,
    input  logic        awready,

    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,

    input  logic        bvalid,
    output logic        bready,

    output logic        dbg_ar_state,
    output logic [1:0]  dbg_w_state
);

    // Handshakes: a beat transfers on the rising edge where valid and ready are
    // both 1; a raised valid, and its payload, hold until that edge.
    typedef enum logic {AR_IDLE = 1'b0, AR_SEND = 1'b1} ar_state_t;
    typedef enum logic [1:0] {W_IDLE = 2'd0, W_SEND = 2'd1, W_RESP = 2'd2} w_state_t;

    ar_state_t ar_state;
    w_state_t  w_state;

    logic inst_pend;
    logic data_pend;
    logic data_rd_pend;

    logic w_acc;
    logic raw_hit;
    logic data_rd_cand;
    logic inst_cand;
    logic ar_data_acc;
    logic ar_inst_acc;
    logic inst_r_ok;
    logic data_r_ok;
    logic data_b_ok;
    logic aw_done;
    logic w_done;

    always_comb begin
        w_acc        = resetn && (w_state == W_IDLE) && data_sram_req && data_sram_wr && !data_pend;
        // An inst fetch of a word with a store in flight must wait for the B response.
        raw_hit      = ((w_state != W_IDLE) && (inst_sram_addr[31:2] == awaddr[31:2])) ||
                       (w_acc && (inst_sram_addr[31:2] == data_sram_addr[31:2]));
        data_rd_cand = data_sram_req && !data_sram_wr && !data_pend;
        inst_cand    = inst_sram_req && !inst_pend && !raw_hit;
        ar_data_acc  = resetn && (ar_state == AR_IDLE) && data_rd_cand;
        ar_inst_acc  = resetn && (ar_state == AR_IDLE) && inst_cand && !data_rd_cand;
        // Pend gating drops R/B beats that belong to nothing outstanding, e.g. after reset.
        inst_r_ok    = resetn && rvalid && (rid == INST_ID) && inst_pend;
        data_r_ok    = resetn && rvalid && (rid == DATA_ID) && data_rd_pend;
        data_b_ok    = resetn && bvalid && (w_state == W_RESP);
        aw_done      = !awvalid || awready;
        w_done       = !wvalid || wready;
    end

    assign inst_sram_addr_ok = ar_inst_acc;
    assign data_sram_addr_ok = ar_data_acc || w_acc;
    assign inst_sram_data_ok = inst_r_ok;
    assign data_sram_data_ok = data_r_ok || data_b_ok;
    assign inst_sram_rdata   = rdata;
    assign data_sram_rdata   = rdata;
    assign rready            = resetn;
    assign dbg_ar_state      = ar_state;
    assign dbg_w_state       = w_state;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            inst_pend    <= 1'b0;
            data_pend    <= 1'b0;
            data_rd_pend <= 1'b0;
        end else begin
            if (ar_inst_acc)
                inst_pend <= 1'b1;
            else if (inst_r_ok)
                inst_pend <= 1'b0;

            if (ar_data_acc || w_acc)
                data_pend <= 1'b1;
            else if (data_r_ok || data_b_ok)
                data_pend <= 1'b0;

            if (ar_data_acc)
                data_rd_pend <= 1'b1;
            else if (data_r_ok)
                data_rd_pend <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ar_state <= AR_IDLE;
            arid     <= '0;
            araddr   <= '0;
            arsize   <= '0;
            arvalid  <= 1'b0;
        end else begin
            case (ar_state)
                AR_IDLE: begin
                    if (ar_data_acc) begin
                        arid     <= DATA_ID;
                        araddr   <= data_sram_addr;
                        arsize   <= {1'b0, data_sram_size};
                        arvalid  <= 1'b1;
                        ar_state <= AR_SEND;
                    end else if (ar_inst_acc) begin
                        arid     <= INST_ID;
                        araddr   <= inst_sram_addr;
                        arsize   <= {1'b0, inst_sram_size};
                        arvalid  <= 1'b1;
                        ar_state <= AR_SEND;
                    end
                end
                AR_SEND: begin
                    if (arready) begin
                        arvalid  <= 1'b0;
                        ar_state <= AR_IDLE;
                    end
                end
                default: ar_state <= AR_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            w_state <= W_IDLE;
            awaddr  <= '0;
            awsize  <= '0;
            wdata   <= '0;
            wstrb   <= '0;
            awvalid <= 1'b0;
            wvalid  <= 1'b0;
            bready  <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (w_acc) begin
                        awaddr  <= data_sram_addr;
                        awsize  <= {1'b0, data_sram_size};
                        wdata   <= data_sram_wdata;
                        wstrb   <= data_sram_wstrb;
                        awvalid <= 1'b1;
                        wvalid  <= 1'b1;
                        w_state <= W_SEND;
                    end
                end
                W_SEND: begin
                    // AW and W complete independently, in either order or together.
                    if (awready)
                        awvalid <= 1'b0;
                    if (wready)
                        wvalid <= 1'b0;
                    if (aw_done && w_done) begin
                        bready  <= 1'b1;
                        w_state <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (bvalid) begin
                        bready  <= 1'b0;
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Bench for sram_axi_bridge: directed cycle checks, then random traffic against
// a word-memory model of both sram-like ports behind a randomly stalling AXI slave.
module tb_sram_axi_bridge;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_sram_req;
    logic [1:0]  inst_sram_size;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        data_sram_req;
    logic        data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic        data_sram_addr_ok;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [2:0]  arsize;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic [2:0]  awsize;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic        bvalid;
    logic        bready;
    logic        dbg_ar_state;
    logic [1:0]  dbg_w_state;

    sram_axi_bridge dut (
        .clk(clk), .resetn(resetn),
        .inst_sram_req(inst_sram_req), .inst_sram_size(inst_sram_size),
        .inst_sram_addr(inst_sram_addr), .inst_sram_addr_ok(inst_sram_addr_ok),
        .inst_sram_data_ok(inst_sram_data_ok), .inst_sram_rdata(inst_sram_rdata),
        .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
        .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
        .data_sram_rdata(data_sram_rdata),
        .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready),
        .dbg_ar_state(dbg_ar_state), .dbg_w_state(dbg_w_state)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Random-phase state: reference memory, slave memory and scoreboards.
    logic [31:0] model_mem [16];
    logic [31:0] slave_mem [16];
    logic [31:0] inst_exp_q [$];
    logic [32:0] data_exp_q [$];
    logic [35:0] r_q [$];
    bit          inst_act, inst_out, data_act, data_out, d_wr;
    logic [3:0]  inst_idx, inst_out_idx, d_idx, aw_idx;
    logic [31:0] d_wdata, w_d;
    logic [3:0]  d_wstrb, w_s;
    bit          aw_got, w_got, b_pend, prev_ar_wait;
    logic [31:0] prev_araddr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++)
            if (strb[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] word_addr(input logic [3:0] idx);
        return 32'h1c00_0000 | {26'h0, idx, 2'b00};
    endfunction

    task automatic init_inputs();
        inst_sram_req = 0; inst_sram_size = 2'b10; inst_sram_addr = '0;
        data_sram_req = 0; data_sram_wr = 0; data_sram_size = 2'b10;
        data_sram_wstrb = 4'hf; data_sram_addr = '0; data_sram_wdata = '0;
        arready = 1; rid = '0; rdata = '0; rvalid = 0;
        awready = 0; wready = 0; bvalid = 0;
    endtask

    task automatic rand_cycle(input bit draining);
        logic [35:0] r_tmp;
        logic [31:0] e;
        logic [32:0] de;
        @(negedge clk);
        if (!inst_act && !draining && $urandom_range(0, 2) == 0) begin
            inst_act = 1;
            inst_idx = 4'($urandom_range(0, 15));
        end
        inst_sram_req  = inst_act;
        inst_sram_addr = word_addr(inst_idx);
        if (!data_act && !draining && $urandom_range(0, 2) == 0) begin
            data_act = 1;
            d_wr     = 1'($urandom_range(0, 1));
            d_idx    = 4'($urandom_range(0, 15));
            d_wdata  = $urandom;
            d_wstrb  = 4'($urandom_range(1, 15));
        end
        // A store to a word whose fetch is still in flight is held back by the requester.
        data_sram_req   = data_act && !(d_wr && inst_out && inst_out_idx == d_idx);
        data_sram_wr    = d_wr;
        data_sram_addr  = word_addr(d_idx);
        data_sram_wdata = d_wdata;
        data_sram_wstrb = d_wstrb;
        arready = ($urandom_range(0, 3) != 0);
        if (r_q.size() > 0 && $urandom_range(0, 2) != 0) begin
            rvalid = 1; rid = r_q[0][35:32]; rdata = r_q[0][31:0];
        end else begin
            rvalid = 0; rid = 4'($urandom_range(0, 15)); rdata = $urandom;
        end
        awready = 1'($urandom_range(0, 1));
        wready  = 1'($urandom_range(0, 1));
        bvalid  = b_pend && ($urandom_range(0, 1) == 1);
        #1;
        if (prev_ar_wait) begin
            check("ar_hold_valid", 32'(arvalid), 1);
            check("ar_hold_addr", araddr, prev_araddr);
        end
        prev_ar_wait = arvalid && !arready;
        prev_araddr  = araddr;
        if (rvalid) begin
            check("r_rready", 32'(rready), 1);
            if (rid == 4'd0) check("r_inst_data_ok", 32'(inst_sram_data_ok), 1);
            else             check("r_data_data_ok", 32'(data_sram_data_ok), 1);
            r_tmp = r_q.pop_front();
        end
        if (data_sram_data_ok) begin
            if (data_exp_q.size() == 0) check("data_spurious_data_ok", 1, 0);
            else begin
                de = data_exp_q.pop_front();
                if (de[32]) check("data_wr_ok_on_b", 32'(bvalid), 1);
                else        check("data_rdata", data_sram_rdata, de[31:0]);
            end
            data_out = 0;
        end
        if (data_sram_addr_ok) begin
            check("data_one_outstanding", 32'(data_out), 0);
            if (d_wr) begin
                model_mem[d_idx] = merge(model_mem[d_idx], d_wdata, d_wstrb);
                data_exp_q.push_back({1'b1, 32'h0});
            end else begin
                data_exp_q.push_back({1'b0, model_mem[d_idx]});
            end
            data_out = 1; data_act = 0;
        end
        if (inst_sram_data_ok) begin
            if (inst_exp_q.size() == 0) check("inst_spurious_data_ok", 1, 0);
            else begin
                e = inst_exp_q.pop_front();
                check("inst_rdata", inst_sram_rdata, e);
            end
            inst_out = 0;
        end
        if (inst_sram_addr_ok) begin
            check("inst_one_outstanding", 32'(inst_out), 0);
            inst_exp_q.push_back(model_mem[inst_idx]);
            inst_out = 1; inst_out_idx = inst_idx; inst_act = 0;
        end
        if (arvalid && arready) begin
            check("arsize", 32'(arsize), 2);
            r_q.push_back({arid, slave_mem[araddr[5:2]]});
        end
        if (awvalid && awready) begin aw_got = 1; aw_idx = awaddr[5:2]; end
        if (wvalid && wready) begin w_got = 1; w_d = wdata; w_s = wstrb; end
        if (bvalid) begin
            check("b_bready", 32'(bready), 1);
            b_pend = 0;
        end
        if (aw_got && w_got) begin
            slave_mem[aw_idx] = merge(slave_mem[aw_idx], w_d, w_s);
            b_pend = 1; aw_got = 0; w_got = 0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        init_inputs();
        resetn = 0;
        repeat (2) @(negedge clk);
        inst_sram_req = 1; data_sram_req = 1; data_sram_wr = 1; rvalid = 1; bvalid = 1;
        #1;
        check("rst_inst_addr_ok", 32'(inst_sram_addr_ok), 0);
        check("rst_data_addr_ok", 32'(data_sram_addr_ok), 0);
        check("rst_inst_data_ok", 32'(inst_sram_data_ok), 0);
        check("rst_data_data_ok", 32'(data_sram_data_ok), 0);
        check("rst_valids", 32'({arvalid, awvalid, wvalid, bready, rready}), 0);
        check("rst_araddr", araddr, 0);
        check("rst_awaddr", awaddr, 0);
        check("rst_states", 32'({dbg_ar_state, dbg_w_state}), 0);
        @(negedge clk); init_inputs(); resetn = 1;

        // Single inst fetch.
        @(negedge clk); inst_sram_req = 1; inst_sram_addr = 32'h1c00_0000; #1;
        check("t1_addr_ok", 32'(inst_sram_addr_ok), 1);
        check("t1_rready", 32'(rready), 1);
        @(negedge clk); inst_sram_req = 0; #1;
        check("t1_arvalid", 32'(arvalid), 1);
        check("t1_araddr", araddr, 32'h1c00_0000);
        check("t1_arid", 32'(arid), 0);
        check("t1_arsize", 32'(arsize), 2);
        @(negedge clk); rvalid = 1; rid = 4'd0; rdata = 32'h0280_0000; #1;
        check("t1_arvalid_drop", 32'(arvalid), 0);
        check("t1_data_ok", 32'(inst_sram_data_ok), 1);
        check("t1_rdata", inst_sram_rdata, 32'h0280_0000);
        @(negedge clk); rvalid = 0; #1;
        check("t1_data_ok_once", 32'(inst_sram_data_ok), 0);

        // Data read wins arbitration over a simultaneous inst read.
        @(negedge clk); arready = 0;
        inst_sram_req = 1; inst_sram_addr = 32'h1c00_0004;
        data_sram_req = 1; data_sram_wr = 0; data_sram_addr = 32'h0000_1000; #1;
        check("t2_data_first", 32'(data_sram_addr_ok), 1);
        check("t2_inst_wait", 32'(inst_sram_addr_ok), 0);
        @(negedge clk); data_sram_req = 0; arready = 1; #1;
        check("t2_arvalid_d", 32'(arvalid), 1);
        check("t2_arid_d", 32'(arid), 1);
        check("t2_araddr_d", araddr, 32'h0000_1000);
        check("t2_inst_wait_send", 32'(inst_sram_addr_ok), 0);
        @(negedge clk); #1;
        check("t2_inst_after", 32'(inst_sram_addr_ok), 1);
        @(negedge clk); inst_sram_req = 0; #1;
        check("t2_arid_i", 32'(arid), 0);
        check("t2_araddr_i", araddr, 32'h1c00_0004);
        @(negedge clk); rvalid = 1; rid = 4'd1; rdata = 32'h1111_2222; #1;
        check("t2_data_ok", 32'(data_sram_data_ok), 1);
        check("t2_data_rdata", data_sram_rdata, 32'h1111_2222);
        check("t2_no_inst_ok", 32'(inst_sram_data_ok), 0);
        @(negedge clk); rid = 4'd0; rdata = 32'h3333_4444; #1;
        check("t2_inst_ok", 32'(inst_sram_data_ok), 1);
        check("t2_inst_rdata", inst_sram_rdata, 32'h3333_4444);
        check("t2_no_data_ok", 32'(data_sram_data_ok), 0);
        @(negedge clk); rvalid = 0;

        // Store with AW accepted two cycles before W; a second data request waits.
        data_sram_req = 1; data_sram_wr = 1; data_sram_addr = 32'h0000_0100;
        data_sram_wdata = 32'hdead_beef; data_sram_wstrb = 4'b0011; #1;
        check("t3_wr_addr_ok", 32'(data_sram_addr_ok), 1);
        @(negedge clk); data_sram_wr = 0; data_sram_addr = 32'h0000_0200; awready = 1; #1;
        check("t3_2nd_blocked_b", 32'(data_sram_addr_ok), 0);
        check("t3_valids_b", 32'({awvalid, wvalid}), 3);
        check("t3_awaddr", awaddr, 32'h0000_0100);
        check("t3_wdata", wdata, 32'hdead_beef);
        check("t3_wstrb", 32'(wstrb), 3);
        @(negedge clk); awready = 0; #1;
        check("t3_valids_c", 32'({awvalid, wvalid}), 1);
        check("t3_2nd_blocked_c", 32'(data_sram_addr_ok), 0);
        @(negedge clk); wready = 1; #1;
        check("t3_valids_d", 32'({awvalid, wvalid}), 1);
        check("t3_state_send", 32'(dbg_w_state), 1);
        @(negedge clk); wready = 0; #1;
        check("t3_state_resp", 32'(dbg_w_state), 2);
        check("t3_bready", 32'(bready), 1);
        check("t3_wvalid_drop", 32'(wvalid), 0);
        check("t3_2nd_blocked_e", 32'(data_sram_addr_ok), 0);
        @(negedge clk); bvalid = 1; #1;
        check("t3_b_data_ok", 32'(data_sram_data_ok), 1);
        check("t3_2nd_blocked_f", 32'(data_sram_addr_ok), 0);
        @(negedge clk); bvalid = 0; #1;
        check("t3_data_ok_once", 32'(data_sram_data_ok), 0);
        check("t3_w_idle", 32'(dbg_w_state), 0);
        check("t3_2nd_accepted", 32'(data_sram_addr_ok), 1);
        @(negedge clk); data_sram_req = 0; #1;
        check("t3_2nd_araddr", araddr, 32'h0000_0200);
        @(negedge clk); rvalid = 1; rid = 4'd1; rdata = 32'h0bad_cafe; #1;
        check("t3_2nd_data_ok", 32'(data_sram_data_ok), 1);
        @(negedge clk); rvalid = 0;

        // Inst fetch of a word with a pending store stalls until B; another word proceeds.
        data_sram_req = 1; data_sram_wr = 1; data_sram_addr = 32'h1c00_0010;
        data_sram_wdata = 32'hcafe_f00d; data_sram_wstrb = 4'hf;
        inst_sram_req = 1; inst_sram_addr = 32'h1c00_0010; #1;
        check("t4_wr_ok", 32'(data_sram_addr_ok), 1);
        check("t4_raw_same_cycle", 32'(inst_sram_addr_ok), 0);
        @(negedge clk); data_sram_req = 0; #1;
        check("t4_raw_pending", 32'(inst_sram_addr_ok), 0);
        @(negedge clk); inst_sram_addr = 32'h1c00_0014; #1;
        check("t4_other_word", 32'(inst_sram_addr_ok), 1);
        @(negedge clk); inst_sram_req = 0; #1;
        check("t4_araddr", araddr, 32'h1c00_0014);
        @(negedge clk); rvalid = 1; rid = 4'd0; rdata = 32'h5555_aaaa; #1;
        check("t4_inst_ok", 32'(inst_sram_data_ok), 1);
        @(negedge clk); rvalid = 0; inst_sram_req = 1; inst_sram_addr = 32'h1c00_0010;
        awready = 1; wready = 1; #1;
        check("t4_raw_send", 32'(inst_sram_addr_ok), 0);
        @(negedge clk); awready = 0; wready = 0; bvalid = 1; #1;
        check("t4_raw_resp", 32'(inst_sram_addr_ok), 0);
        check("t4_b_ok", 32'(data_sram_data_ok), 1);
        @(negedge clk); bvalid = 0; #1;
        check("t4_raw_clear", 32'(inst_sram_addr_ok), 1);
        @(negedge clk); inst_sram_req = 0; #1;
        check("t4_araddr2", araddr, 32'h1c00_0010);
        @(negedge clk); rvalid = 1; rid = 4'd0; rdata = 32'hcafe_f00d; #1;
        check("t4_inst_ok2", 32'(inst_sram_data_ok), 1);
        @(negedge clk); rvalid = 0;

        // AR stalled by arready=0 for five cycles.
        arready = 0; inst_sram_req = 1; inst_sram_addr = 32'h1c00_0020; #1;
        check("t5_addr_ok", 32'(inst_sram_addr_ok), 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            inst_sram_addr = 32'h1c00_0024;
            data_sram_req = 1; data_sram_wr = 0; data_sram_addr = 32'h0000_2000; #1;
            check("t5_arvalid_hold", 32'(arvalid), 1);
            check("t5_araddr_hold", araddr, 32'h1c00_0020);
            check("t5_no_addr_ok", 32'({inst_sram_addr_ok, data_sram_addr_ok}), 0);
        end
        @(negedge clk); data_sram_req = 0; inst_sram_req = 0; arready = 1; #1;
        check("t5_arvalid_last", 32'(arvalid), 1);
        @(negedge clk); rvalid = 1; rid = 4'd0; #1;
        check("t5_arvalid_drop", 32'(arvalid), 0);
        check("t5_inst_ok", 32'(inst_sram_data_ok), 1);
        @(negedge clk); rvalid = 0;

        // Reset with both AR_SEND and W_SEND active.
        arready = 0; awready = 0; wready = 0;
        data_sram_req = 1; data_sram_wr = 1; data_sram_addr = 32'h0000_0300;
        data_sram_wdata = 32'h1234_5678; data_sram_wstrb = 4'hf;
        inst_sram_req = 1; inst_sram_addr = 32'h1c00_0040; #1;
        check("t6_both_ok", 32'({inst_sram_addr_ok, data_sram_addr_ok}), 3);
        @(negedge clk); data_sram_req = 0; inst_sram_req = 0; #1;
        check("t6_states_busy", 32'({dbg_ar_state, dbg_w_state}), 3'b101);
        check("t6_valids_busy", 32'({arvalid, awvalid, wvalid}), 7);
        @(negedge clk); resetn = 0;
        @(negedge clk); resetn = 1; #1;
        check("t6_valids_rst", 32'({arvalid, awvalid, wvalid, bready}), 0);
        check("t6_states_rst", 32'({dbg_ar_state, dbg_w_state}), 0);
        check("t6_regs_rst", araddr | awaddr | wdata, 0);
        @(negedge clk); rvalid = 1; rid = 4'd0; bvalid = 1; #1;
        check("t6_late_inst", 32'(inst_sram_data_ok), 0);
        check("t6_late_b", 32'(data_sram_data_ok), 0);
        @(negedge clk); rid = 4'd1; #1;
        check("t6_late_data_r", 32'(data_sram_data_ok), 0);
        @(negedge clk); init_inputs(); resetn = 0;

        // Random traffic against the memory model.
        for (int i = 0; i < 16; i++) begin
            model_mem[i] = 32'hc0de_0000 ^ (32'h0101_0101 * i);
            slave_mem[i] = model_mem[i];
        end
        inst_act = 0; inst_out = 0; data_act = 0; data_out = 0; d_wr = 0;
        inst_idx = '0; inst_out_idx = '0; d_idx = '0; aw_idx = '0;
        d_wdata = '0; d_wstrb = 4'hf; w_d = '0; w_s = '0;
        aw_got = 0; w_got = 0; b_pend = 0; prev_ar_wait = 0; prev_araddr = '0;
        @(negedge clk); resetn = 1;
        for (int c = 0; c < 4000; c++) rand_cycle(1'b0);
        begin
            bit drained;
            drained = 0;
            for (int c = 0; c < 2000 && !drained; c++) begin
                rand_cycle(1'b1);
                drained = !inst_act && !data_act && !inst_out && !data_out &&
                          (r_q.size() == 0) && !b_pend;
            end
            check("drain_done", 32'(drained), 1);
        end
        for (int i = 0; i < 16; i++) check("mem_final", slave_mem[i], model_mem[i]);
        check("inst_q_empty", 32'(inst_exp_q.size()), 0);
        check("data_q_empty", 32'(data_exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
